// File: rtl/memory_arbiter.sv
// memory_arbiter: multiplexes the core's instruction and data request ports onto one
// memory bus, holding one captured request at a time with round-robin on contention.
module memory_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic       PORT_I    = 1'b0;
  localparam logic       PORT_D    = 1'b1;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_last;
  logic        r_instr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_busy;

  assign w_busy = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

  // Grant decision: fresh arbitration in IDLE, direct handover to the other port on completion
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (imemory_valid && dmemory_valid) begin
          if (r_last == PORT_I) begin
            w_grant_d = 1'b1;
          end else begin
            w_grant_i = 1'b1;
          end
        end else if (imemory_valid) begin
          w_grant_i = 1'b1;
        end else if (dmemory_valid) begin
          w_grant_d = 1'b1;
        end else begin
          w_grant_i = 1'b0;
          w_grant_d = 1'b0;
        end
      end
      // The finishing port's valid still belongs to the old request, so only the other port may win
      ST_BUSY_I: begin
        if (memory_ready && dmemory_valid) begin
          w_grant_d = 1'b1;
        end else begin
          w_grant_d = 1'b0;
        end
      end
      ST_BUSY_D: begin
        if (memory_ready && imemory_valid) begin
          w_grant_i = 1'b1;
        end else begin
          w_grant_i = 1'b0;
        end
      end
      default: begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
      end
    endcase
  end

  // Next-state selection; an unknown encoding falls back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (w_grant_i) begin
      w_state_nxt = ST_BUSY_I;
    end else if (w_grant_d) begin
      w_state_nxt = ST_BUSY_D;
    end else if (!w_busy) begin
      w_state_nxt = ST_IDLE;
    end else if (memory_ready) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, round-robin pointer and holding register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_last  <= PORT_I;
      r_instr <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_wstrb <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_last  <= PORT_I;
        r_instr <= imemory_instr;
        r_addr  <= imemory_addr;
        r_wdata <= imemory_wdata;
        r_wstrb <= imemory_wstrb;
      end else if (w_grant_d) begin
        r_last  <= PORT_D;
        r_instr <= dmemory_instr;
        r_addr  <= dmemory_addr;
        r_wdata <= dmemory_wdata;
        r_wstrb <= dmemory_wstrb;
      end else begin
        r_last  <= r_last;
        r_instr <= r_instr;
        r_addr  <= r_addr;
        r_wdata <= r_wdata;
        r_wstrb <= r_wstrb;
      end
    end
  end

  assign memory_valid  = w_busy;
  assign memory_instr  = r_instr;
  assign memory_addr   = r_addr;
  assign memory_wdata  = r_wdata;
  assign memory_wstrb  = r_wstrb;

  // Responses reach only the owning port; everything else reads zero
  assign imemory_ready = (r_state == ST_BUSY_I) && memory_ready;
  assign dmemory_ready = (r_state == ST_BUSY_D) && memory_ready;
  assign imemory_rdata = imemory_ready ? memory_rdata : 32'h0000_0000;
  assign dmemory_rdata = dmemory_ready ? memory_rdata : 32'h0000_0000;

endmodule
